// File: rtl/int_res_mem_arbiter_if.sv
// Requester and bank-side signal bundle for the intermediate-result memory arbiter.
// slave = arbiter view, master = requesters plus the CIM banks.
interface int_res_mem_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int NUM_BANKS = 4
);
    logic [NUM_REQ-1:0]              req_i;
    logic [NUM_REQ-1:0]              we_i;
    logic [NUM_REQ-1:0]              width_i;
    logic [NUM_REQ-1:0][15:0]        addr_i;
    logic [NUM_REQ-1:0][29:0]        wdata_i;
    logic [NUM_REQ-1:0]              grant_o;
    logic [NUM_REQ-1:0]              rvalid_o;
    logic [29:0]                     rdata_o;
    logic                            busy_o;
    logic [NUM_BANKS-1:0]            bank_en_o;
    logic                            bank_we_o;
    logic [13:0]                     bank_addr_o;
    logic [14:0]                     bank_wdata_o;
    logic [NUM_BANKS-1:0][14:0]      bank_rdata_i;
    logic                            addr_err_o;

    modport slave (
        input  req_i, we_i, width_i, addr_i, wdata_i, bank_rdata_i,
        output grant_o, rvalid_o, rdata_o, busy_o,
               bank_en_o, bank_we_o, bank_addr_o, bank_wdata_o, addr_err_o
    );

    modport master (
        output req_i, we_i, width_i, addr_i, wdata_i, bank_rdata_i,
        input  grant_o, rvalid_o, rdata_o, busy_o,
               bank_en_o, bank_we_o, bank_addr_o, bank_wdata_o, addr_err_o
    );
endinterface

// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter sharing the banked intermediate-result memory; DOUBLE accesses split into two words.
// Optional range checking is enabled by defining INT_RES_ADDR_CHECK_EN.
module int_res_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int BANK_WORDS = 14336,
    parameter int NUM_BANKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    int_res_mem_arbiter_if.slave  bus
);
    localparam int   REQ_W        = $clog2(NUM_REQ);
    localparam int   BANK_W       = $clog2(NUM_BANKS);
    localparam logic DOUBLE_WIDTH = 1'b1;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [13:0]       baddr;
        logic              err;
    } dec_t;

    // Threshold compare against each bank base; the highest base passed selects the bank.
    function automatic dec_t decode(input logic [15:0] a);
        dec_t        d;
        logic [16:0] base;
        d.bank = '0;
        base   = '0;
        for (int k = 1; k < NUM_BANKS; k++) begin
            if ({1'b0, a} >= 17'(k * BANK_WORDS)) begin
                d.bank = BANK_W'(k);
                base   = 17'(k * BANK_WORDS);
            end
        end
        d.baddr = 14'({1'b0, a} - base);
`ifdef INT_RES_ADDR_CHECK_EN
        d.err = ({1'b0, a} >= 17'(NUM_BANKS * BANK_WORDS));
`else
        d.err = 1'b0;
`endif
        return d;
    endfunction

    state_t              state_reg, state_next;
    logic [REQ_W-1:0]    ptr_reg;
    logic [REQ_W-1:0]    win_reg;
    logic                we_reg;
    logic                dbl_reg;
    logic [15:0]         addr_reg;
    logic [29:0]         wdata_reg;
    logic [14:0]         hi_reg;
    logic [BANK_W-1:0]   prev_bank_reg;
    logic                prev_err_reg;
    logic [29:0]         rdata_reg;
    logic [NUM_REQ-1:0]  rvalid_reg;
    logic                addr_err_reg;

    logic                any_req;
    logic [REQ_W-1:0]    win_next;
    int                  cand;
    logic                access;
    logic                second_word;
    logic                bank_we;
    logic [14:0]         bank_wdata;
    logic [15:0]         cur_addr;
    dec_t                dec;
    logic [14:0]         rd_word;

    // Search starts just after the last winner, so the previous winner has lowest priority.
    always_comb begin
        any_req  = 1'b0;
        win_next = ptr_reg;
        cand     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_req && bus.req_i[cand[REQ_W-1:0]]) begin
                any_req  = 1'b1;
                win_next = cand[REQ_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = FIRST;
                end
            end
            FIRST: begin
                if (dbl_reg == DOUBLE_WIDTH) begin
                    state_next = SECOND;
                end else if (!we_reg) begin
                    state_next = RESP;
                end else begin
                    state_next = IDLE;
                end
            end
            SECOND: begin
                state_next = we_reg ? IDLE : RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        access      = 1'b0;
        second_word = 1'b0;
        bank_we     = 1'b0;
        bank_wdata  = '0;
        case (state_reg)
            FIRST: begin
                access  = 1'b1;
                bank_we = we_reg;
                if (we_reg) begin
                    bank_wdata = (dbl_reg == DOUBLE_WIDTH) ? wdata_reg[29:15] : wdata_reg[14:0];
                end
            end
            SECOND: begin
                access      = 1'b1;
                second_word = 1'b1;
                bank_we     = we_reg;
                if (we_reg) begin
                    bank_wdata = wdata_reg[14:0];
                end
            end
            default: begin
                access = 1'b0;
            end
        endcase
    end

    assign cur_addr = second_word ? (addr_reg + 16'd1) : addr_reg;
    assign dec      = decode(cur_addr);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_en
            assign bus.bank_en_o[gi] = access && !dec.err && (dec.bank == BANK_W'(gi));
        end
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign bus.grant_o[gi] = (state_reg == FIRST) && (win_reg == REQ_W'(gi));
        end
    endgenerate

    assign bus.bank_we_o    = bank_we;
    assign bus.bank_wdata_o = bank_wdata;
    assign bus.bank_addr_o  = access ? dec.baddr : 14'd0;
    assign bus.busy_o       = (state_reg != IDLE);

    // Bank data arrives one cycle after the enable, so the bank/err of that access is remembered.
    assign rd_word = prev_err_reg ? 15'd0 : bus.bank_rdata_i[prev_bank_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= REQ_W'(NUM_REQ - 1);
            win_reg       <= '0;
            we_reg        <= 1'b0;
            dbl_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            hi_reg        <= '0;
            prev_bank_reg <= '0;
            prev_err_reg  <= 1'b0;
            rdata_reg     <= '0;
            rvalid_reg    <= '0;
        end else begin
            rvalid_reg    <= '0;
            prev_bank_reg <= dec.bank;
            prev_err_reg  <= dec.err;
            if (state_reg == IDLE && any_req) begin
                win_reg   <= win_next;
                ptr_reg   <= win_next;
                we_reg    <= bus.we_i[win_next];
                dbl_reg   <= bus.width_i[win_next];
                addr_reg  <= bus.addr_i[win_next];
                wdata_reg <= bus.wdata_i[win_next];
            end
            if (state_reg == SECOND && !we_reg) begin
                hi_reg <= rd_word;
            end
            if (state_reg == RESP) begin
                rvalid_reg[win_reg] <= 1'b1;
                rdata_reg <= (dbl_reg == DOUBLE_WIDTH) ? {hi_reg, rd_word}
                                                       : {{15{rd_word[14]}}, rd_word};
            end
        end
    end

`ifdef INT_RES_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_reg <= 1'b0;
        end else if (access && dec.err) begin
            addr_err_reg <= 1'b1;
        end
    end
`else
    assign addr_err_reg = 1'b0;
`endif

    assign bus.rvalid_o   = rvalid_reg;
    assign bus.rdata_o    = rdata_reg;
    assign bus.addr_err_o = addr_err_reg;

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Self-checking bench for int_res_mem_arbiter: bank memory model plus a flat-address reference memory.
// Honours INT_RES_ADDR_CHECK_EN the same way the design does.
module tb_int_res_mem_arbiter;
    localparam int NUM_REQ    = 3;
    localparam int NUM_BANKS  = 4;
    localparam int BANK_WORDS = 14336;
    localparam int TOTAL      = NUM_BANKS * BANK_WORDS;
`ifdef INT_RES_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int_res_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_BANKS(NUM_BANKS)) ifc();

    int_res_mem_arbiter #(
        .NUM_REQ(NUM_REQ),
        .BANK_WORDS(BANK_WORDS),
        .NUM_BANKS(NUM_BANKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    // Bank model: 16384-word slots per bank so any 14-bit bank address is storable.
    logic [14:0] mem [NUM_BANKS*16384];
    logic [NUM_BANKS-1:0][14:0] rd_q = '0;
    assign ifc.bank_rdata_i = rd_q;

    always @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (ifc.bank_en_o[b]) begin
                if (ifc.bank_we_o) begin
                    mem[b*16384 + int'(ifc.bank_addr_o)] <= ifc.bank_wdata_o;
                end else begin
                    rd_q[b] <= mem[b*16384 + int'(ifc.bank_addr_o)];
                end
            end
        end
    end

    // Reference memory indexed by flat word address.
    logic [14:0] ref_mem [int];
    int written[$];

    function automatic logic [14:0] rd_ref(input int w);
        if (CHECK_EN && w >= TOTAL) return 15'd0;
        if (ref_mem.exists(w)) return ref_mem[w];
        return 15'd0;
    endfunction

    task automatic ref_write(input int w, input logic [14:0] d);
        if (!(CHECK_EN && w >= TOTAL)) ref_mem[w] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ifc.busy_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ifc.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", ifc.busy_o, n);
        end
    endtask

    // One requester transaction, checked cycle by cycle; cycle 0 is the IDLE cycle seeing req.
    task automatic run_txn(input int r, input bit we, input bit dbl, input int a,
                           input logic [29:0] wd, output logic [29:0] rd_seen);
        logic [14:0] w0;
        logic [29:0] exp_rd;
        logic [14:0] exp_wd;
        logic [NUM_BANKS-1:0] exp_en;
        logic [13:0] exp_baddr;
        int exp_bank, w, cyc, nwords;

        w0     = rd_ref(a);
        exp_rd = dbl ? {rd_ref(a), rd_ref(a + 1)} : {{15{w0[14]}}, w0};
        nwords = dbl ? 2 : 1;
        rd_seen = '0;
        $display("txn req=%0d %s %s addr=%0d wdata=%h", r, we ? "WR" : "RD", dbl ? "DOUBLE" : "SINGLE", a, wd);

        ifc.req_i[r]   = 1'b1;
        ifc.we_i[r]    = we;
        ifc.width_i[r] = dbl;
        ifc.addr_i[r]  = 16'(a);
        ifc.wdata_i[r] = wd;
        tick();

        checks++;
        if (ifc.grant_o !== NUM_REQ'(1 << r)) begin
            errors++;
            $display("FAIL grant: got %b required %b", ifc.grant_o, NUM_REQ'(1 << r));
        end
        // Inputs are free to change once granted.
        ifc.req_i[r]   = 1'b0;
        ifc.we_i[r]    = 1'($urandom);
        ifc.width_i[r] = 1'($urandom);
        ifc.addr_i[r]  = 16'($urandom);
        ifc.wdata_i[r] = 30'($urandom);

        for (int k = 0; k < nwords; k++) begin
            if (k == 1) begin
                tick();
                checks++;
                if (ifc.grant_o !== '0) begin
                    errors++;
                    $display("FAIL grant_second: got %b required 0", ifc.grant_o);
                end
            end
            w         = a + k;
            exp_bank  = (w >= TOTAL) ? NUM_BANKS - 1 : w / BANK_WORDS;
            exp_baddr = 14'(w - exp_bank * BANK_WORDS);
            exp_en    = (CHECK_EN && w >= TOTAL) ? '0 : NUM_BANKS'(1 << exp_bank);
            checks++;
            if (ifc.bank_en_o !== exp_en) begin
                errors++;
                $display("FAIL bank_en word%0d: got %b required %b", k, ifc.bank_en_o, exp_en);
            end
            checks++;
            if (ifc.bank_addr_o !== exp_baddr) begin
                errors++;
                $display("FAIL bank_addr word%0d: got %0d required %0d", k, ifc.bank_addr_o, exp_baddr);
            end
            checks++;
            if (ifc.bank_we_o !== we) begin
                errors++;
                $display("FAIL bank_we word%0d: got %b required %b", k, ifc.bank_we_o, we);
            end
            if (we) begin
                exp_wd = (dbl && k == 0) ? wd[29:15] : wd[14:0];
                checks++;
                if (ifc.bank_wdata_o !== exp_wd) begin
                    errors++;
                    $display("FAIL bank_wdata word%0d: got %h required %h", k, ifc.bank_wdata_o, exp_wd);
                end
                ref_write(w, exp_wd);
            end
        end

        if (we) begin
            tick();
            checks++;
            if (ifc.busy_o !== 1'b0 || ifc.rvalid_o !== '0) begin
                errors++;
                $display("FAIL write_end: busy=%b rvalid=%b required 0/0", ifc.busy_o, ifc.rvalid_o);
            end
        end else begin
            cyc = nwords;
            while (cyc < 10) begin
                tick();
                cyc++;
                if (ifc.rvalid_o !== '0) break;
            end
            checks++;
            if (cyc != nwords + 2) begin
                errors++;
                $display("FAIL rvalid_latency: got cycle %0d required %0d", cyc, nwords + 2);
            end
            checks++;
            if (ifc.rvalid_o !== NUM_REQ'(1 << r)) begin
                errors++;
                $display("FAIL rvalid: got %b required %b", ifc.rvalid_o, NUM_REQ'(1 << r));
            end
            checks++;
            if (ifc.rdata_o !== exp_rd) begin
                errors++;
                $display("FAIL rdata: got %h required %h", ifc.rdata_o, exp_rd);
            end
            rd_seen = ifc.rdata_o;
            checks++;
            if (ifc.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL read_end_busy: got %b required 0", ifc.busy_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ifc.grant_o !== '0 || ifc.rvalid_o !== '0) begin
            errors++;
            $display("FAIL reset_grant_rvalid: got %b/%b required 0/0", ifc.grant_o, ifc.rvalid_o);
        end
        checks++;
        if (ifc.rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0", ifc.rdata_o);
        end
        checks++;
        if (ifc.busy_o !== 1'b0 || ifc.addr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_err: got %b/%b required 0/0", ifc.busy_o, ifc.addr_err_o);
        end
        checks++;
        if ({ifc.bank_en_o, ifc.bank_we_o, ifc.bank_addr_o, ifc.bank_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_bank: got en=%b we=%b addr=%h wdata=%h required 0", ifc.bank_en_o,
                     ifc.bank_we_o, ifc.bank_addr_o, ifc.bank_wdata_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        logic [29:0] rd;
        logic [14:0] got;
        run_txn(1, 1'b1, 1'b1, 14335, 30'h1234_5678, rd);
        got = mem[14335];
        checks++;
        if (got !== 15'h2468) begin
            errors++;
            $display("FAIL dbl_wr_bank0_14335: got %h required 2468", got);
        end
        got = mem[1*16384 + 0];
        checks++;
        if (got !== 15'h5678) begin
            errors++;
            $display("FAIL dbl_wr_bank1_0: got %h required 5678", got);
        end
        run_txn(0, 1'b1, 1'b0, 28673, 30'h0000_7FFF, rd);
        run_txn(0, 1'b0, 1'b0, 28673, 30'h0, rd);
        checks++;
        if (rd !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL single_rd_sext: got %h required 3fffffff", rd);
        end
        run_txn(2, 1'b1, 1'b1, 100, 30'h0000_8002, rd);
        run_txn(2, 1'b0, 1'b1, 100, 30'h0, rd);
        checks++;
        if (rd !== 30'h0000_8002) begin
            errors++;
            $display("FAIL double_rd: got %h required 00008002", rd);
        end
    endtask

    task automatic test_round_robin();
        int gidx[4];
        int gt[4];
        int gcount;
        logic [14:0] w;
        logic [29:0] exp_rd;
        w      = rd_ref(14335);
        exp_rd = {{15{w[14]}}, w};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ifc.req_i[i]   = 1'b1;
            ifc.we_i[i]    = 1'b0;
            ifc.width_i[i] = 1'b0;
            ifc.addr_i[i]  = 16'd14335;
        end
        gcount = 0;
        for (int t = 1; t <= 40 && gcount < 4; t++) begin
            tick();
            if (ifc.rvalid_o !== '0) begin
                checks++;
                if (ifc.rdata_o !== exp_rd) begin
                    errors++;
                    $display("FAIL rr_rdata: got %h required %h", ifc.rdata_o, exp_rd);
                end
            end
            if (ifc.grant_o !== '0) begin
                gidx[gcount] = (ifc.grant_o === 3'b001) ? 0 : (ifc.grant_o === 3'b010) ? 1 :
                               (ifc.grant_o === 3'b100) ? 2 : -1;
                gt[gcount]   = t;
                $display("rr grant=%b at cycle %0d", ifc.grant_o, t);
                gcount++;
            end
        end
        ifc.req_i = '0;
        checks++;
        if (gcount != 4) begin
            errors++;
            $display("FAIL rr_grant_count: got %0d required 4", gcount);
        end
        for (int k = 0; k < gcount; k++) begin
            checks++;
            if (gidx[k] != k % NUM_REQ) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", k, gidx[k], k % NUM_REQ);
            end
            if (k > 0) begin
                checks++;
                if (gt[k] - gt[k-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: got %0d required 3", k, gt[k] - gt[k-1]);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_random();
        int bounds[8] = '{0, 14335, 14336, 28671, 28672, 43007, 43008, 57342};
        logic [29:0] rd;
        int r, a, idx;
        bit dbl;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, NUM_REQ - 1);
            if (written.size() == 0 || ($urandom % 2) == 0) begin
                a   = ($urandom % 3 == 0) ? bounds[$urandom_range(0, 7)] : $urandom_range(0, TOTAL - 2);
                dbl = 1'($urandom);
                run_txn(r, 1'b1, dbl, a, 30'($urandom), rd);
                written.push_back(a);
                if (dbl) written.push_back(a + 1);
            end else begin
                idx = $urandom_range(0, written.size() - 1);
                a   = written[idx];
                dbl = 1'($urandom) && ref_mem.exists(a + 1);
                run_txn(r, 1'b0, dbl, a, 30'($urandom), rd);
            end
        end
    endtask

    task automatic test_addr_range();
        logic [29:0] rd;
        run_txn(1, 1'b1, 1'b1, 57343, 30'h2AAA_5555, rd);
        checks++;
        if (ifc.addr_err_o !== CHECK_EN) begin
            errors++;
            $display("FAIL addr_err_after_wr: got %b required %b", ifc.addr_err_o, CHECK_EN);
        end
        run_txn(0, 1'b0, 1'b1, 57343, 30'h0, rd);
        checks++;
        if (ifc.addr_err_o !== CHECK_EN) begin
            errors++;
            $display("FAIL addr_err_after_rd: got %b required %b", ifc.addr_err_o, CHECK_EN);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ifc.addr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_clear: got %b required 0", ifc.addr_err_o);
        end
    endtask

    task automatic test_reset_mid_op();
        ifc.req_i[1]   = 1'b1;
        ifc.we_i[1]    = 1'b1;
        ifc.width_i[1] = 1'b1;
        ifc.addr_i[1]  = 16'd200;
        ifc.wdata_i[1] = 30'($urandom);
        tick();
        checks++;
        if (ifc.grant_o !== 3'b010) begin
            errors++;
            $display("FAIL midrst_grant: got %b required 010", ifc.grant_o);
        end
        ifc.req_i[1] = 1'b0;
        tick();
        checks++;
        if (ifc.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_second: busy got %b required 1", ifc.busy_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ifc.grant_o, ifc.rvalid_o, ifc.rdata_o, ifc.busy_o, ifc.bank_en_o, ifc.bank_we_o,
             ifc.bank_addr_o, ifc.bank_wdata_o, ifc.addr_err_o} !== 72'd0) begin
            errors++;
            $display("FAIL midrst_outputs: grant=%b rvalid=%b rdata=%h busy=%b en=%b we=%b required all 0",
                     ifc.grant_o, ifc.rvalid_o, ifc.rdata_o, ifc.busy_o, ifc.bank_en_o, ifc.bank_we_o);
        end
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i += 2) begin
            ifc.req_i[i]   = 1'b1;
            ifc.we_i[i]    = 1'b0;
            ifc.width_i[i] = 1'b0;
            ifc.addr_i[i]  = 16'd14335;
        end
        tick();
        checks++;
        if (ifc.grant_o !== 3'b001) begin
            errors++;
            $display("FAIL midrst_pointer: grant got %b required 001", ifc.grant_o);
        end
        ifc.req_i = '0;
        wait_idle();
    endtask

    initial begin
        ifc.req_i   = '0;
        ifc.we_i    = '0;
        ifc.width_i = '0;
        ifc.addr_i  = '0;
        ifc.wdata_i = '0;
        test_reset();
        test_spec_vectors();
        test_round_robin();
        test_random();
        test_addr_range();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
